// File: rtl/mem_bus_requester.sv
// MEM-stage load/store bus master: decodes the EX/MEM instruction, runs one req/ack
// transaction per access, stalls the pipeline meanwhile, and reports address/bus errors.
module mem_bus_requester #(
    parameter int TIMEOUT_CYC = 16,
    parameter int EXC_ADEL    = 4,
    parameter int EXC_ADES    = 5,
    parameter int EXC_DBE     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_instr,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [4:0]  exc_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic               err_q, flushed_q, ld_q, sgn_q;
    size_t              size_q;
    logic [1:0]         lane_q;

    logic               is_acc, is_ld, sgn, misaligned, issue, timeout_hit;
    size_t              size;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic               unused_instr;

    assign unused_instr = ^mem_instr[25:0];

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        is_acc = 1'b1;
        is_ld  = 1'b1;
        sgn    = 1'b0;
        size   = SZ_W;
        case (mem_instr[31:26])
            6'h23: size = SZ_W;
            6'h21: begin size = SZ_H; sgn = 1'b1; end
            6'h25: size = SZ_H;
            6'h20: begin size = SZ_B; sgn = 1'b1; end
            6'h24: size = SZ_B;
            6'h2B: is_ld = 1'b0;
            6'h29: begin size = SZ_H; is_ld = 1'b0; end
            6'h28: begin size = SZ_B; is_ld = 1'b0; end
            default: begin is_acc = 1'b0; is_ld = 1'b0; end
        endcase
    end

    assign misaligned  = is_acc && ((size == SZ_W && mem_addr[1:0] != 2'b00) ||
                                    (size == SZ_H && mem_addr[0]));
    assign issue       = (state == IDLE) && is_acc && !misaligned && !flush;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        be_d    = 4'hF;
        wdata_d = mem_wdata;
        case (size)
            SZ_H: begin
                be_d    = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_d = {2{mem_wdata[15:0]}};
            end
            SZ_B: begin
                be_d    = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] d, input size_t sz,
                                           input logic sg, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = d[{lane[1], 4'b0000} +: 16];
        case (sz)
            SZ_B:    return sg ? {{24{b[7]}}, b} : {24'b0, b};
            SZ_H:    return sg ? {{16{h[15]}}, h} : {16'b0, h};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d    = state;
        stall      = 1'b0;
        load_valid = 1'b0;
        exc_valid  = 1'b0;
        exc_code   = 5'd0;
        case (state)
            IDLE: begin
                if (misaligned && !flush) begin
                    exc_valid = 1'b1;
                    exc_code  = is_ld ? 5'(EXC_ADEL) : 5'(EXC_ADES);
                end
                if (issue) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack || timeout_hit) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                // A flush seen at any point of the transaction discards its result.
                if (!flushed_q && !flush) begin
                    if (err_q) begin
                        exc_valid = 1'b1;
                        exc_code  = 5'(EXC_DBE);
                    end else begin
                        load_valid = ld_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
            ld_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= SZ_W;
            lane_q    <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            load_data <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    err_q     <= 1'b0;
                    flushed_q <= 1'b0;
                    if (issue) begin
                        bus_req   <= 1'b1;
                        bus_we    <= !is_ld;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_be    <= be_d;
                        bus_wdata <= wdata_d;
                        ld_q      <= is_ld;
                        sgn_q     <= sgn;
                        size_q    <= size;
                        lane_q    <= mem_addr[1:0];
                    end
                end
                REQ: begin
                    if (flush) flushed_q <= 1'b1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (ld_q) load_data <= extend(bus_rdata, size_q, sgn_q, lane_q);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            bus_req <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_requester.sv
// Self-checking bench for mem_bus_requester: directed cases plus randomized load/store
// sequences compared against a transaction-level reference model.
module tb_mem_bus_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_instr;
    logic        flush;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall, load_valid;
    logic [31:0] load_data;
    logic        exc_valid;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    mem_bus_requester dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_instr(mem_instr), .flush(flush), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .exc_valid(exc_valid), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One instruction through the MEM stage; ack_k / flush_k are REQ-cycle indices
    // (0 = first REQ cycle), negative or >=16 ack means the bridge never answers.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_k, input int flush_k);
        bit          acc, is_ld, sgn, mis, timeout, flushed;
        int          nbytes, last_k;
        logic [31:0] exp_be, exp_wd, exp_ld, mask, val;
        acc = 1'b1; is_ld = 1'b1; sgn = 1'b0; nbytes = 4;
        case (op)
            6'h23: nbytes = 4;
            6'h21: begin nbytes = 2; sgn = 1'b1; end
            6'h25: nbytes = 2;
            6'h20: begin nbytes = 1; sgn = 1'b1; end
            6'h24: nbytes = 1;
            6'h2B: is_ld = 1'b0;
            6'h29: begin nbytes = 2; is_ld = 1'b0; end
            6'h28: begin nbytes = 1; is_ld = 1'b0; end
            default: begin acc = 1'b0; is_ld = 1'b0; end
        endcase
        mis     = acc && ((addr % nbytes) != 0);
        exp_be  = ((32'd1 << nbytes) - 32'd1) << (addr % 4);
        exp_wd  = (nbytes == 4) ? wd :
                  (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : (wd & 32'hFF) * 32'h0101_0101;
        mask    = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val     = (rd >> (8 * (addr % 4))) & mask;
        if (sgn && ((val >> (8 * nbytes - 1)) & 32'd1) == 32'd1) val = val | ~mask;
        exp_ld  = val;
        timeout = (ack_k < 0) || (ack_k >= 16);
        last_k  = timeout ? 15 : ack_k;
        flushed = (flush_k >= 0) && (flush_k <= last_k);

        @(negedge clk);
        mem_instr = {op, 26'($urandom)};
        mem_addr  = addr;
        mem_wdata = wd;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        #1;
        if (!acc || mis) begin
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_exc", 32'(exc_valid), 32'(mis));
            if (mis) check("adr_code", 32'(exc_code), is_ld ? 32'd4 : 32'd5);
        end else begin
            check("issue_stall", 32'(stall), 32'd1);
            check("issue_exc", 32'(exc_valid), 32'd0);
            @(posedge clk);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                bus_ack   = (k == ack_k);
                bus_rdata = (k == ack_k) ? rd : $urandom;
                flush     = (k == flush_k);
                #1;
                check("req_held", 32'(bus_req), 32'd1);
                check("req_stall", 32'(stall), 32'd1);
                if (k == 0) begin
                    check("bus_we", 32'(bus_we), 32'(!is_ld));
                    check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                    check("bus_be", 32'(bus_be), exp_be);
                    if (!is_ld) check("bus_wdata", bus_wdata, exp_wd);
                end
                @(posedge clk);
                if (k == last_k) break;
            end
            @(negedge clk);
            bus_ack = 1'b0;
            flush   = 1'b0;
            #1;
            check("done_stall", 32'(stall), 32'd0);
            check("done_req", 32'(bus_req), 32'd0);
            check("load_valid", 32'(load_valid), 32'(is_ld && !timeout && !flushed));
            check("dbe_valid", 32'(exc_valid), 32'(timeout && !flushed));
            if (timeout && !flushed) check("dbe_code", 32'(exc_code), 32'd7);
            if (is_ld && !timeout && !flushed) check("load_data", load_data, exp_ld);
        end
        @(posedge clk);
        @(negedge clk);
        mem_instr = NOP;
        #1;
        check("after_req", 32'(bus_req), 32'd0);
        check("after_stall", 32'(stall), 32'd0);
    endtask

    logic [5:0] ops [10];
    initial begin
        ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h00, 6'h0F};
        reset     = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_instr = NOP;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_lv", 32'(load_valid), 32'd0);
        check("rst_exc", 32'(exc_valid), 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_ldata", load_data, 32'd0);
        reset = 1'b0;

        run_op(6'h23, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, -1);
        run_op(6'h28, 32'h0000_7F03, 32'h0000_00A5, 32'h0, 1, -1);
        run_op(6'h20, 32'h0000_0002, 32'h0, 32'h0080_0000, 0, -1);
        run_op(6'h24, 32'h0000_0002, 32'h0, 32'h0080_0000, 2, -1);
        run_op(6'h21, 32'h0000_0001, 32'h0, 32'h0, 0, -1);
        run_op(6'h2B, 32'h0000_0402, 32'h1234_5678, 32'h0, 0, -1);
        run_op(6'h23, 32'h0000_2000, 32'h0, 32'h0, -1, -1);
        run_op(6'h23, 32'h0000_2004, 32'h0, 32'h1111_2222, 15, -1);
        run_op(6'h21, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 2, 0);
        run_op(6'h29, 32'h0000_3002, 32'hCAFE_8765, 32'h0, 0, -1);

        // bus_ack while idle must be ignored
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("idle_ack_lv", 32'(load_valid), 32'd0);
        check("idle_ack_req", 32'(bus_req), 32'd0);

        // reset in the middle of a transaction
        @(negedge clk);
        mem_instr = {6'h23, 26'h0};
        mem_addr  = 32'h0000_0100;
        @(negedge clk);
        mem_instr = NOP;
        #1;
        check("mid_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_lv", 32'(load_valid), 32'd0);

        for (int i = 0; i < 80; i++) begin
            int ack_k, flush_k;
            ack_k   = int'($urandom_range(0, 17));
            flush_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_op(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom, ack_k, flush_k);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
